// File: rtl/icarus_pkg.sv
// Shared constants and receiver state encoding for the Icarus getwork receiver.
package icarus_pkg;

    localparam int WORK_BYTES = 84;
    localparam int WORK_BITS  = WORK_BYTES * 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/icarus_work_rx_uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, bit timing and START/DATA/STOP FSM.
// Exposes rx_idle only when ICARUS_RX_TIMEOUT_EN is defined (used by the gap timer).
module uart_rx_byte
    import icarus_pkg::*;
#(
    parameter int comm_clk_frequency = 100_000_000,
    parameter int baud_rate          = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       stop_err
`ifdef ICARUS_RX_TIMEOUT_EN
   ,output logic       rx_idle
`endif
);

    localparam int BIT_CYCLES  = comm_clk_frequency / baud_rate;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int TMR_W       = $clog2(BIT_CYCLES + 1);

    logic             sync_1;
    logic             sync_2;
    rx_state_t        state;
    rx_state_t        state_next;
    logic [TMR_W-1:0] timer;
    logic [2:0]       bit_idx;
    logic             tick;

    assign tick = (timer == '0);

    // The line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= RxD;
            sync_2 <= sync_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        case (state)
            RX_IDLE:  if (!sync_2) state_next = RX_START;
            RX_START: if (tick) state_next = sync_2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_idx == 3'd7) state_next = RX_STOP;
            RX_STOP: begin
                if (tick) begin
                    byte_valid = sync_2;
                    stop_err   = !sync_2;
                    state_next = sync_2 ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: if (sync_2) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    // Timer is preloaded to half a bit while idle so START samples mid start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= '0;
            bit_idx   <= '0;
            byte_data <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    timer   <= TMR_W'(HALF_CYCLES - 1);
                    bit_idx <= '0;
                end
                RX_START, RX_STOP: begin
                    timer <= tick ? TMR_W'(BIT_CYCLES - 1) : timer - 1'b1;
                end
                RX_DATA: begin
                    if (tick) begin
                        timer     <= TMR_W'(BIT_CYCLES - 1);
                        byte_data <= {sync_2, byte_data[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: timer <= timer;
            endcase
        end
    end

`ifdef ICARUS_RX_TIMEOUT_EN
    assign rx_idle = (state == RX_IDLE);
`endif

endmodule

// File: rtl/icarus_work_rx.sv
// Getwork frame assembler: collects WORK_BYTES good UART bytes into one work word.
// Optional inter-byte gap timeout is built when ICARUS_RX_TIMEOUT_EN is defined.
module icarus_work_rx #(
    parameter int comm_clk_frequency = 100_000_000,
    parameter int baud_rate          = 115_200,
    parameter int WORK_BYTES         = icarus_pkg::WORK_BYTES,
    parameter int GAP_TIMEOUT_CYCLES = comm_clk_frequency / 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    RxD,
    output logic [8*WORK_BYTES-1:0] work_data,
    output logic                    work_valid,
    output logic                    rx_busy,
    output logic                    frame_err
);

    localparam int W     = 8 * WORK_BYTES;
    localparam int CNT_W = $clog2(WORK_BYTES + 1);

    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             stop_err;
    logic [W-1:0]     shift_reg;
    logic [CNT_W-1:0] count;
    logic             last_byte;

`ifdef ICARUS_RX_TIMEOUT_EN
    localparam int GAP_W = $clog2(GAP_TIMEOUT_CYCLES + 1);
    logic             rx_idle;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_timeout;
`endif

    uart_rx_byte #(
        .comm_clk_frequency(comm_clk_frequency),
        .baud_rate         (baud_rate)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .RxD       (RxD),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .stop_err  (stop_err)
`ifdef ICARUS_RX_TIMEOUT_EN
       ,.rx_idle   (rx_idle)
`endif
    );

    assign rx_busy   = (count != '0);
    assign last_byte = (count == CNT_W'(WORK_BYTES - 1));

`ifdef ICARUS_RX_TIMEOUT_EN
    // Gap time only accrues between bytes of a frame that has already started.
    assign gap_timeout = rx_busy && rx_idle && (gap_cnt == GAP_W'(GAP_TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (byte_valid || !rx_busy || gap_timeout) begin
            gap_cnt <= '0;
        end else if (rx_idle) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end
`endif

    // Aborts only zero the byte count; the next full frame overwrites shift_reg completely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            count      <= '0;
            work_data  <= '0;
            work_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            work_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (stop_err) begin
                count     <= '0;
                frame_err <= 1'b1;
            end else if (byte_valid) begin
                shift_reg <= {shift_reg[W-9:0], byte_data};
                if (last_byte) begin
                    work_data  <= {shift_reg[W-9:0], byte_data};
                    work_valid <= 1'b1;
                    count      <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end
`ifdef ICARUS_RX_TIMEOUT_EN
            else if (gap_timeout) begin
                count     <= '0;
                frame_err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: doc/icarus_work_rx.md
# icarus_work_rx

Serial getwork receiver for the Icarus-protocol miner top. It deserialises the 8N1 UART stream on `RxD`, assembles 84 bytes into one 672-bit work word and presents the word with a single-cycle load strobe to the hashing core's work/nonce loader. It sits directly downstream of the host serial link: on the bench, `serial_transmit` drives this block's `RxD`. A partial frame never disturbs the last complete work word.

## Interface

Parameters:
- `comm_clk_frequency`, 100_000_000: clock frequency in Hz.
- `baud_rate`, 115_200: serial bit rate.
- `WORK_BYTES`, 84: bytes per frame.
- `GAP_TIMEOUT_CYCLES`, comm_clk_frequency/10: allowed idle time between bytes of one frame (100 ms).

Ports:
- `clk` input 1: single clock for all logic.
- `rst_n` input 1: asynchronous, active-low reset.
- `RxD` input 1: UART line, idle high, asynchronous to `clk`.
- `work_data` output 672: last complete frame. The first byte received is in [671:664] and the last in [7:0].
- `work_valid` output 1: one-cycle strobe marking a new `work_data`.
- `rx_busy` output 1: a frame is partially received.
- `frame_err` output 1: one-cycle pulse when a bad stop bit is seen or a gap timeout occurs.

## Operation

- Reset values: all outputs are 0; the byte counter is 0; the receiver state is IDLE.
- `RxD` passes through a 2-flop synchroniser with reset value 1.
- `BIT_CYCLES` = comm_clk_frequency / baud_rate, using integer division. `HALF_CYCLES` = BIT_CYCLES/2.
- Byte receiver states:
  - IDLE: a falling edge on the synchronised RxD moves to START.
  - START: after HALF_CYCLES, sample the line. If it is low, go to DATA. If it is high, treat it as a glitch and return to IDLE.
  - DATA: take 8 samples spaced BIT_CYCLES apart, LSB first.
  - STOP: after BIT_CYCLES, sample the line.
    - Sample = 1: emit the byte and go to IDLE.
    - Sample = 0: pulse `frame_err`, discard the byte, and go to IDLE only once the line is back high.
- Frame assembler:
  - Each good byte shifts into an internal 672-bit shift register from the LSB end.
  - The byte counter increments with each good byte; `rx_busy` = (count != 0).
  - On byte WORK_BYTES, the shift register is copied to `work_data`, `work_valid` pulses, and the counter returns to 0.
- A framing error aborts the frame: the counter goes to 0 and `work_data` is untouched.
- A frame longer than 84 bytes is split: byte 85 starts the next frame.
- Simultaneous framing error and frame completion cannot occur, because only good bytes count.
- Reset in mid-frame: the partial frame and `work_data` are both cleared, and no strobe is issued.

## Timing

- The `RxD` falling edge reaches the receiver after 2 cycles (synchroniser).
- The stop-bit sample falls at HALF_CYCLES + 9×BIT_CYCLES after the detected edge.
- `work_valid` and the new `work_data` appear on the cycle after the stop-bit sample of the final byte.
- `work_data` holds until the next completed frame.
- A frame takes at least 84×10×BIT_CYCLES cycles. At 1 MHz and 115200 baud, BIT_CYCLES = 8, giving ≈6720 cycles.
- The gap counter clears on every good byte and counts only while `rx_busy` is 1 and the receiver is in IDLE.

## Configuration

- `ICARUS_RX_TIMEOUT_EN` defined:
  - When the gap counter reaches GAP_TIMEOUT_CYCLES, the partial frame is discarded, the counter returns to 0 and `frame_err` pulses.
  - This resynchronises the link after a host abort.
- `ICARUS_RX_TIMEOUT_EN` undefined:
  - The gap counter is not built.
  - A partial frame waits indefinitely and completes with the next bytes received.

## Structure

- Shared package `icarus_pkg`: `WORK_BITS` = 672, `WORK_BYTES` = 84 and the receiver state enum.
- Sub-module `uart_rx_byte` contains the synchroniser, the bit timing and the START/DATA/STOP FSM. Its outputs are `byte_data[7:0]`, `byte_valid` and `stop_err`.
- The top level holds the shift register, the byte counter, the gap timer and the output register.

## Test plan

- Single frame: send the 672-bit value 000007ff0000318e…01000000 at 1 MHz / 115200 baud. Expect exactly one `work_valid`, with `work_data` equal to that value and `rx_busy` low afterwards.
- Back-to-back frames: send all-0x00 followed by all-0xFF. Expect two strobes; `work_data` is 0 after the first and all ones after the second.
- Stop-bit error: corrupt the stop bit of byte 40. Expect a `frame_err` pulse and no `work_valid`; a following clean 84-byte frame is then accepted intact.
- Glitch: a low pulse on `RxD` shorter than HALF_CYCLES produces no byte and no change in the counter.
- Timeout, with `ICARUS_RX_TIMEOUT_EN` and GAP_TIMEOUT_CYCLES = 1000: send 50 bytes and idle for 1000 cycles. Expect `frame_err`; a fresh 84-byte frame then strobes with the correct data.
- Reset in mid-frame: assert `rst_n` low after 30 bytes. All outputs go to 0; the next full frame strobes correctly.
